seg7_bcd_reader: RTL

//  Reverse of the BCD->7-seg path. Samples an active-low 7-segment pattern, waits until it is

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/seg7_decode.sv | 39 +++
 rtl/seg7_bcd_reader.sv | 131 +++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment read-back path.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [3:0] BCD_ERR = 4'hF;

   // StTrack: waiting for a stable pattern; StLocked: pattern already handled
   typedef enum logic {
      StTrack  = 1'b0,
      StLocked = 1'b1
   } state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment pattern to BCD decoder.
// Ports:
//   pattern  in  7  active-low segments {g..a}
//   is_digit out 1  pattern is one of the ten digit codes
//   is_blank out 1  pattern is all segments off
//   bcd      out 4  decoded digit, BCD_ERR when not a digit
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [6:0] pattern,
   output logic       is_digit,
   output logic       is_blank,
   output logic [3:0] bcd
);

   always_comb begin
      is_digit = 1'b1;
      is_blank = 1'b0;
      bcd      = BCD_ERR;
      unique case (pattern)
         SEG_0:     bcd = 4'd0;
         SEG_1:     bcd = 4'd1;
         SEG_2:     bcd = 4'd2;
         SEG_3:     bcd = 4'd3;
         SEG_4:     bcd = 4'd4;
         SEG_5:     bcd = 4'd5;
         SEG_6:     bcd = 4'd6;
         SEG_7:     bcd = 4'd7;
         SEG_8:     bcd = 4'd8;
         SEG_9:     bcd = 4'd9;
         SEG_BLANK: begin
            is_digit = 1'b0;
            is_blank = 1'b1;
         end
         default:   is_digit = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_bcd_reader.sv
// Reads back an active-low 7-segment pattern: synchronises it, waits until it is stable for
// STABLE_CYCLES samples, decodes it and offers the result over a one-entry valid/ready output.
// Ports:
//   clk        in   1  clock, rising edge
//   reset      in   1  synchronous active-high reset
//   seg_n      in   7  active-low segments {g..a}, asynchronous to clk
//   out_ready  in   1  consumer accepts the result when high with out_valid
//   out_valid  out  1  out_bcd/out_err hold a result
//   out_bcd    out  4  decoded digit, 4'hF on error
//   out_err    out  1  stable pattern was neither a digit nor blank
//   overrun    out  1  one-cycle pulse when a new result was dropped (output full)
module seg7_bcd_reader
   import seg7_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned CNT_W         = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] seg_n,
   input  logic       out_ready,
   output logic       out_valid,
   output logic [3:0] out_bcd,
   output logic       out_err,
   output logic       overrun
);

   localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);

   logic [6:0]       meta_q, sync_q, samp_q;
   logic [6:0]       last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   state_t           state_q, state_d;
   logic             emit;

   logic             is_digit, is_blank;
   logic [3:0]       dec_bcd;

   logic             valid_q, valid_d;
   logic [3:0]       bcd_q, bcd_d;
   logic             err_q, err_d;
   logic             overrun_q, overrun_d;

   seg7_decode u_decode (
      .pattern  (samp_q),
      .is_digit (is_digit),
      .is_blank (is_blank),
      .bcd      (dec_bcd)
   );

   // Stability tracking; emit is evaluated on the cycle the counter reaches its target,
   // so the result register loads on that same edge.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      emit    = 1'b0;
      unique case (state_q)
         StTrack: begin
            if (sync_q != samp_q) begin
               cnt_d = '0;
            end else begin
               if (cnt_q != STABLE_CNT) cnt_d = cnt_q + 1'b1;
               if (cnt_d == STABLE_CNT) begin
                  state_d = StLocked;
                  if (is_blank) begin
                     last_d = SEG_BLANK;
                  end else if (samp_q != last_q) begin
                     emit   = 1'b1;
                     last_d = samp_q;
                  end
               end
            end
         end
         StLocked: begin
            if (sync_q != samp_q) begin
               cnt_d   = '0;
               state_d = StTrack;
            end
         end
         default: state_d = StTrack;
      endcase
   end

   // One-entry output register; a result arriving while full and not draining is dropped.
   always_comb begin
      valid_d   = valid_q;
      bcd_d     = bcd_q;
      err_d     = err_q;
      overrun_d = emit & valid_q & ~out_ready;
      if (emit && (!valid_q || out_ready)) begin
         valid_d = 1'b1;
         bcd_d   = is_digit ? dec_bcd : BCD_ERR;
         err_d   = ~is_digit;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q    <= SEG_BLANK;
         sync_q    <= SEG_BLANK;
         samp_q    <= SEG_BLANK;
         last_q    <= SEG_BLANK;
         cnt_q     <= '0;
         state_q   <= StTrack;
         valid_q   <= 1'b0;
         bcd_q     <= 4'd0;
         err_q     <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         meta_q    <= seg_n;
         sync_q    <= meta_q;
         samp_q    <= sync_q;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         state_q   <= state_d;
         valid_q   <= valid_d;
         bcd_q     <= bcd_d;
         err_q     <= err_d;
         overrun_q <= overrun_d;
      end
   end

   assign out_valid = valid_q;
   assign out_bcd   = bcd_q;
   assign out_err   = err_q;
   assign overrun   = overrun_q;

endmodule
